// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings and default field widths.
package fpu_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  typedef enum logic [1:0] {
    RM_NEAREST = 2'd0,
    RM_ZERO    = 2'd1,
    RM_PINF    = 2'd2,
    RM_NINF    = 2'd3
  } rmode_e;

endpackage

// File: rtl/fpu_align_shift.sv
// Right-shifts a significand by the exponent difference, folding every lost bit into bit 0.
module fpu_align_shift #(
  parameter int unsigned F     = 27,
  parameter int unsigned EXP_W = 8
) (
  input  logic [F-1:0]     sig,
  input  logic [EXP_W-1:0] shift,
  output logic [F-1:0]     frac
);

  logic [F-1:0] shifted;
  logic [F-1:0] lost_mask;
  logic         sticky;

  always_comb begin
    shifted   = sig >> shift;
    lost_mask = ~({F{1'b1}} << shift);
    sticky    = |(sig & lost_mask);
    // Past F positions nothing survives except the sticky summary.
    if (32'(shift) >= F) begin
      frac = {{(F-1){1'b0}}, |sig};
    end else begin
      frac = {shifted[F-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fpu_align_pipe.sv
// Two-stage elastic operand-alignment pipeline for add/subtract: S1 compares and swaps,
// S2 performs the sticky alignment shift and registers the outputs.
module fpu_align_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  localparam int unsigned F    = MAN_W + 4,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     opa,
  input  logic [W-1:0]     opb,
  input  logic             add,
  input  logic [1:0]       rmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [F-1:0]     fracta_out,
  output logic [F-1:0]     fractb_out,
  output logic [EXP_W-1:0] exp_dn_out,
  output logic             sign,
  output logic             nan_sign,
  output logic             result_zero_sign,
  output logic             fasu_op
);

  // S1 combinational decode
  logic             sa, sb_eff;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] ma, mb;
  logic [F-1:0]     sig_a, sig_b;
  logic             a_ge_b, mag_eq, nan_a, nan_b;
  logic             c_fasu, c_rzs, c_sign, c_nan_sign;

  always_comb begin
    sa         = opa[W-1];
    sb_eff     = opb[W-1] ^ ~add;
    ea         = opa[W-2:MAN_W];
    eb         = opb[W-2:MAN_W];
    ma         = opa[MAN_W-1:0];
    mb         = opb[MAN_W-1:0];
    ea_eff     = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff     = (eb == '0) ? EXP_W'(1) : eb;
    sig_a      = {|ea, ma, 3'b000};
    sig_b      = {|eb, mb, 3'b000};
    a_ge_b     = {ea, ma} >= {eb, mb};
    mag_eq     = {ea, ma} == {eb, mb};
    nan_a      = (&ea) & (|ma);
    nan_b      = (&eb) & (|mb);
    c_fasu     = ~(sa ^ sb_eff);
    c_rzs      = (rmode == RM_NINF) ? (sa | sb_eff) : (sa & sb_eff);
    // Exact cancellation takes the rounding-mode dependent zero sign.
    c_sign     = (mag_eq & ~c_fasu) ? c_rzs : (a_ge_b ? sa : sb_eff);
    c_nan_sign = nan_a ? sa : (nan_b ? sb_eff : 1'b0);
  end

  // Handshake
  logic ready_en_q;
  logic s1_valid_q, out_valid_q;
  logic s2_ready, accept;

  assign s2_ready = ~out_valid_q | out_ready;
  assign in_ready = ready_en_q & (~s1_valid_q | s2_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Stage 1 registers
  logic [F-1:0]     s1_fracta_q, s1_sigb_q;
  logic [EXP_W-1:0] s1_exp_q, s1_shift_q;
  logic             s1_sign_q, s1_nan_sign_q, s1_rzs_q, s1_fasu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_fracta_q   <= '0;
      s1_sigb_q     <= '0;
      s1_exp_q      <= '0;
      s1_shift_q    <= '0;
      s1_sign_q     <= 1'b0;
      s1_nan_sign_q <= 1'b0;
      s1_rzs_q      <= 1'b0;
      s1_fasu_q     <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_fracta_q   <= a_ge_b ? sig_a : sig_b;
        s1_sigb_q     <= a_ge_b ? sig_b : sig_a;
        s1_exp_q      <= a_ge_b ? ea_eff : eb_eff;
        s1_shift_q    <= a_ge_b ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
        s1_sign_q     <= c_sign;
        s1_nan_sign_q <= c_nan_sign;
        s1_rzs_q      <= c_rzs;
        s1_fasu_q     <= c_fasu;
      end
    end
  end

  // Stage 2: alignment shift and output registers
  logic [F-1:0] aligned_b;

  fpu_align_shift #(
    .F    (F),
    .EXP_W(EXP_W)
  ) u_align_shift (
    .sig  (s1_sigb_q),
    .shift(s1_shift_q),
    .frac (aligned_b)
  );

  logic [F-1:0]     fracta_q, fractb_q;
  logic [EXP_W-1:0] exp_dn_q;
  logic             sign_q, nan_sign_q, rzs_q, fasu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      fracta_q    <= '0;
      fractb_q    <= '0;
      exp_dn_q    <= '0;
      sign_q      <= 1'b0;
      nan_sign_q  <= 1'b0;
      rzs_q       <= 1'b0;
      fasu_q      <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        fracta_q   <= s1_fracta_q;
        fractb_q   <= aligned_b;
        exp_dn_q   <= s1_exp_q;
        sign_q     <= s1_sign_q;
        nan_sign_q <= s1_nan_sign_q;
        rzs_q      <= s1_rzs_q;
        fasu_q     <= s1_fasu_q;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign fracta_out       = fracta_q;
  assign fractb_out       = fractb_q;
  assign exp_dn_out       = exp_dn_q;
  assign sign             = sign_q;
  assign nan_sign         = nan_sign_q;
  assign result_zero_sign = rzs_q;
  assign fasu_op          = fasu_q;

endmodule

// File: tb/tb_fpu_align_pipe.sv
// Scoreboard bench for fpu_align_pipe: expected results are queued at accept and
// compared when the pipeline hands them out.
module tb_fpu_align_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int F  = MW + 4;
  localparam int W  = 1 + EW + MW;

  typedef struct packed {
    logic [F-1:0]  fa;
    logic [F-1:0]  fb;
    logic [EW-1:0] e;
    logic          s;
    logic          ns;
    logic          rzs;
    logic          fasu;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  opa = '0, opb = '0;
  logic          add = 1'b1;
  logic [1:0]    rmode = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [F-1:0]  fracta_out, fractb_out;
  logic [EW-1:0] exp_dn_out;
  logic          sign, nan_sign, result_zero_sign, fasu_op;

  int   total = 0;
  int   bad = 0;
  res_t sb_q[$];

  fpu_align_pipe #(
    .EXP_W(EW),
    .MAN_W(MW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .opa             (opa),
    .opb             (opb),
    .add             (add),
    .rmode           (rmode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fracta_out      (fracta_out),
    .fractb_out      (fractb_out),
    .exp_dn_out      (exp_dn_out),
    .sign            (sign),
    .nan_sign        (nan_sign),
    .result_zero_sign(result_zero_sign),
    .fasu_op         (fasu_op)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_res();
    res_t r;
    r = {fracta_out, fractb_out, exp_dn_out, sign, nan_sign, result_zero_sign, fasu_op};
    return r;
  endfunction

  // Reference: bit-serial sticky shift, independent of the RTL mask formulation.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ad, input logic [1:0] rm);
    logic          sa, sbe, na, nb, a_big, eq, st;
    logic [EW-1:0] ea, eb, xa, xb;
    logic [MW-1:0] ma, mb;
    logic [F-1:0]  siga, sigb, sm;
    int            d;
    res_t          r;
    sa    = a[W-1];
    sbe   = b[W-1] ^ ~ad;
    ea    = a[W-2:MW];
    eb    = b[W-2:MW];
    ma    = a[MW-1:0];
    mb    = b[MW-1:0];
    xa    = (ea == 0) ? 8'd1 : ea;
    xb    = (eb == 0) ? 8'd1 : eb;
    siga  = {ea != 0, ma, 3'b000};
    sigb  = {eb != 0, mb, 3'b000};
    a_big = (ea > eb) || (ea == eb && ma >= mb);
    eq    = (a[W-2:0] == b[W-2:0]);
    if (a_big) begin
      r.fa = siga; sm = sigb; r.e = xa; d = int'(xa) - int'(xb);
    end else begin
      r.fa = sigb; sm = siga; r.e = xb; d = int'(xb) - int'(xa);
    end
    st = 1'b0;
    for (int i = 0; i < d; i++) begin
      st = st | sm[0];
      sm = sm >> 1;
    end
    sm[0]  = sm[0] | st;
    r.fb   = sm;
    r.fasu = (sa == sbe);
    r.rzs  = (rm == 2'd3) ? (sa | sbe) : (sa & sbe);
    r.s    = (eq && !r.fasu) ? r.rzs : (a_big ? sa : sbe);
    na     = (ea == 8'hFF) && (ma != 0);
    nb     = (eb == 8'hFF) && (mb != 0);
    r.ns   = na ? sa : (nb ? sbe : 1'b0);
    return r;
  endfunction

  task automatic junk_inputs();
    opa   = $urandom;
    opb   = $urandom;
    add   = 1'($urandom_range(0, 1));
    rmode = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (cur_res() !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", cur_res()); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pre_edge_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_edge_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency();
    res_t e;
    e = '{fa: 27'h4000AA8, fb: 27'h20AAD54, e: 8'h81, s: 1'b0, ns: 1'b0, rzs: 1'b0, fasu: 1'b1};
    out_ready = 1'b1;
    @(negedge clk);
    opa = 32'h4002AB55; opb = 32'h40800155; add = 1'b1; rmode = 2'd0; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_accept got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    junk_inputs();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cycle1 got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_cycle2 got=%b want=1", out_valid); end
    total++; if (cur_res() !== e) begin bad++; $display("FAIL lat_data got=%h want=%h", cur_res(), e); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_vectors();
    localparam int N = 9;
    logic [W-1:0] va[N], vb[N];
    logic         vadd[N];
    logic [1:0]   vrm[N];
    res_t         vexp[N];
    res_t         e;
    int           idx, got;
    logic         acc;
    va[0] = 32'h4002AB55; vb[0] = 32'h40800155; vadd[0] = 1; vrm[0] = 0;
    vexp[0] = '{fa: 27'h4000AA8, fb: 27'h20AAD54, e: 8'h81, s: 0, ns: 0, rzs: 0, fasu: 1};
    va[1] = 32'h4002AB55; vb[1] = 32'h40800155; vadd[1] = 0; vrm[1] = 0;
    vexp[1] = '{fa: 27'h4000AA8, fb: 27'h20AAD54, e: 8'h81, s: 1, ns: 0, rzs: 0, fasu: 0};
    va[2] = 32'h3F82AB55; vb[2] = 32'hC0000155; vadd[2] = 1; vrm[2] = 0;
    vexp[2] = '{fa: 27'h4000AA8, fb: 27'h20AAD54, e: 8'h80, s: 1, ns: 0, rzs: 0, fasu: 0};
    va[3] = 32'h3F800000; vb[3] = 32'h3F800000; vadd[3] = 0; vrm[3] = 3;
    vexp[3] = '{fa: 27'h4000000, fb: 27'h4000000, e: 8'h7F, s: 1, ns: 0, rzs: 1, fasu: 0};
    va[4] = 32'h3F800000; vb[4] = 32'h3F800000; vadd[4] = 0; vrm[4] = 0;
    vexp[4] = '{fa: 27'h4000000, fb: 27'h4000000, e: 8'h7F, s: 0, ns: 0, rzs: 0, fasu: 0};
    va[5] = 32'h7F000000; vb[5] = 32'h3F800001; vadd[5] = 1; vrm[5] = 0;
    vexp[5] = '{fa: 27'h4000000, fb: 27'h0000001, e: 8'hFE, s: 0, ns: 0, rzs: 0, fasu: 1};
    va[6] = 32'h7FC00001; vb[6] = 32'hFF800001; vadd[6] = 1; vrm[6] = 0;
    va[7] = 32'h3F800000; vb[7] = 32'hFFC00000; vadd[7] = 1; vrm[7] = 1;
    va[8] = 32'h00000003; vb[8] = 32'h00800001; vadd[8] = 1; vrm[8] = 2;
    for (int i = 6; i < N; i++) vexp[i] = model(va[i], vb[i], vadd[i], vrm[i]);

    out_ready = 1'b1;
    idx = 0; got = 0;
    @(negedge clk);
    opa = va[0]; opb = vb[0]; add = vadd[0]; rmode = vrm[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < N; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL vec_unexpected got=%h want=none", cur_res());
        end else begin
          e = sb_q.pop_front();
          if (cur_res() !== e) begin bad++; $display("FAIL vec_%0d got=%h want=%h", got, cur_res(), e); end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (in_valid) begin
        total++;
        if (!in_ready) begin bad++; $display("FAIL vec_throughput got=0 want=1 idx=%0d", idx); end
      end
      @(posedge clk); #1;
      if (acc) begin
        sb_q.push_back(vexp[idx]);
        idx++;
        if (idx < N) begin
          opa = va[idx]; opb = vb[idx]; add = vadd[idx]; rmode = vrm[idx];
        end else begin
          in_valid = 1'b0;
          junk_inputs();
        end
      end
    end
    if (got < N) begin total++; bad++; $display("FAIL vec_timeout got=%0d want=%0d", got, N); end
  endtask

  task automatic test_random();
    localparam int N = 60;
    int   sent, got;
    logic acc;
    res_t e, m;
    logic [W-1:0] ra;
    sent = 0; got = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected got=%h want=none", cur_res());
        end else begin
          e = sb_q.pop_front();
          if (cur_res() !== e) begin bad++; $display("FAIL rnd_%0d got=%h want=%h", got, cur_res(), e); end
        end
        got++;
      end
      acc = in_valid && in_ready;
      m = model(opa, opb, add, rmode);
      @(posedge clk); #1;
      if (acc) begin
        sb_q.push_back(m);
        sent++;
      end
      if (acc || !in_valid) begin
        junk_inputs();
        if ($urandom_range(0, 1) == 1) begin
          ra = opa;
          opb[W-2:MW] = ra[W-2:MW] - 8'($urandom_range(0, 30));
        end
        in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (got < N) begin total++; bad++; $display("FAIL rnd_timeout got=%0d want=%0d", got, N); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa[3], pb[3];
    int   idx, got;
    logic acc;
    res_t e;
    pa[0] = 32'h4002AB55; pb[0] = 32'h40800155;
    pa[1] = 32'h3F82AB55; pb[1] = 32'hC0000155;
    pa[2] = 32'h7F000000; pb[2] = 32'h3F800001;
    idx = 0; got = 0;
    @(negedge clk);
    out_ready = 1'b0;
    opa = pa[0]; opb = pb[0]; add = 1'b1; rmode = 2'd0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc == 6) begin
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", idx); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      end
      if (out_valid && !out_ready && cyc >= 3 && sb_q.size() > 0) begin
        total++;
        if (cur_res() !== sb_q[0]) begin bad++; $display("FAIL bp_hold got=%h want=%h", cur_res(), sb_q[0]); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL bp_unexpected got=%h want=none", cur_res());
        end else begin
          e = sb_q.pop_front();
          if (cur_res() !== e) begin bad++; $display("FAIL bp_out_%0d got=%h want=%h", got, cur_res(), e); end
        end
        got++;
      end
      acc = in_valid && in_ready;
      e = model(opa, opb, add, rmode);
      @(posedge clk); #1;
      if (acc) begin
        sb_q.push_back(e);
        idx++;
        if (idx < 3) begin
          opa = pa[idx]; opb = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc == 6) out_ready = 1'b1;
    end
    if (got < 3) begin total++; bad++; $display("FAIL bp_timeout got=%0d want=3", got); end
  endtask

  task automatic test_reset_midflight();
    res_t e;
    int   got;
    out_ready = 1'b0;
    @(negedge clk);
    opa = 32'h4002AB55; opb = 32'h40800155; add = 1'b1; rmode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    opa = 32'h3F82AB55; opb = 32'hC0000155;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_%0d got=%b want=0", i, out_valid); end
    end
    e = '{fa: 27'h4000000, fb: 27'h0000001, e: 8'hFE, s: 0, ns: 0, rzs: 0, fasu: 1};
    opa = 32'h7F000000; opb = 32'h3F800001; add = 1'b1; rmode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        total++;
        if (cur_res() !== e) begin bad++; $display("FAIL mid_after got=%h want=%h", cur_res(), e); end
        got = 1;
      end
    end
    if (got == 0) begin total++; bad++; $display("FAIL mid_after_timeout got=none want=%h", e); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_align_pipe.md
FPU_ALIGN_PIPE -- requirements
Module: fpu_align_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored mantissa width; F = MAN_W+4 is the aligned fraction width: hidden, mantissa, guard, round, sticky.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  input operand pair valid.
REQ-006 SHALL have port in_ready  out  1  block can accept an operand pair.
REQ-007 SHALL have ports opa and opb  in  1+EXP_W+MAN_W  IEEE-style operands: sign, exponent, mantissa.
REQ-008 SHALL have port add  in  1  1 = add, 0 = subtract.
REQ-009 SHALL have port rmode  in  2  rounding mode: 0 nearest-even, 1 zero, 2 +inf, 3 -inf.
REQ-010 SHALL have port out_valid  out  1  aligned result valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-012 SHALL have ports fracta_out and fractb_out  out  F  aligned fractions; fracta_out belongs to the larger-magnitude operand.
REQ-013 SHALL have port exp_dn_out  out  EXP_W  common (larger) exponent.
REQ-014 SHALL have ports sign, nan_sign, result_zero_sign and fasu_op  out  1 each.

Function
REQ-015 SHALL be a two-stage elastic pipeline.
  - S1: unpack, NaN detect, magnitude compare/swap, shift amount.
  - S2: align shift with sticky, register outputs.
REQ-016 SHALL have a latency of 2 cycles from accept (in_valid&in_ready) to out_valid, and a throughput of 1 pair per cycle when out_ready=1.
REQ-017 SHALL advance each stage when that stage is empty or the next stage advances; in_ready = ~S1_valid | S1 advancing.
REQ-018 SHALL hold all outputs stable while out_valid=1 and out_ready=0; no pair is dropped or duplicated.
REQ-019 SHALL treat exponent 0 as denormal: hidden bit 0, effective exponent 1.
REQ-019A SHALL treat a non-zero exponent as normal: hidden bit 1.
REQ-020 SHALL form the effective sign of opb as opb sign XOR ~add.
REQ-021 SHALL set fasu_op = ~(sa XOR sb_eff), where 1 = effective addition.
REQ-022 SHALL order operands by {exponent, mantissa}, select the larger as A, and set exp_dn_out = A's effective exponent.
REQ-023 SHALL form fracta_out = {hidden, mantissa, 3'b000} of A.
REQ-023A SHALL form fractb_out = B's {hidden, mantissa, 3'b000} shifted right by d = expA-expB, with bit 0 = OR of bit 0 and all shifted-out bits (sticky).
REQ-024 SHALL saturate the shift when d ≥ F: fractb_out = {F-1 zeros, OR of B's significand}.
REQ-025 SHALL set sign = sign of A (sb_eff if A is opb).
REQ-025A SHALL, when magnitudes are equal and fasu_op=0, set sign = result_zero_sign.
REQ-026 SHALL set result_zero_sign = (sa | sb_eff) when rmode=3, else (sa & sb_eff).
REQ-027 SHALL detect NaN internally as exponent all-ones with mantissa ≠ 0.
REQ-027A SHALL set nan_sign = sa if opa is NaN, else sb_eff if opb is NaN, else 0.
REQ-028 SHALL sample add and rmode with the operands at accept, so that later changes do not affect in-flight pairs.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear both stage valids, so that out_valid=0.
REQ-029A SHALL, while rst_n=0, clear all output data registers to 0 and hold in_ready=0.
REQ-030 SHALL discard in-flight pairs on reset mid-operation.
REQ-030A SHALL raise in_ready in the first clk edge after rst_n deasserts.

Structure
REQ-031 SHALL place the rmode encodings (RM_NEAREST, RM_ZERO, RM_PINF, RM_NINF) and default widths in shared package fpu_pkg.
REQ-032 SHALL implement the S2 shifter as sub-module fpu_align_shift (params F, EXP_W; in: significand, shift; out: aligned fraction with sticky).

Verification
REQ-033 SHALL cover: opa=0x4002AB55, opb=0x40800155, add=1 -> fracta_out=0x4000AA8, fractb_out=0x20AAD54, exp_dn_out=0x81, sign=0, fasu_op=1, two cycles after accept.
REQ-034 SHALL cover: same operands, add=0 -> identical fractions and exponent, sign=1, fasu_op=0.
REQ-034A SHALL cover: opa=0x3F82AB55, opb=0xC0000155, add=1 -> fracta_out=0x4000AA8, fractb_out=0x20AAD54, exp_dn_out=0x80, sign=1, fasu_op=0.
REQ-035 SHALL cover: opa=opb=0x3F800000, add=0 -> with rmode=3: result_zero_sign=1, sign=1; with rmode=0: both 0.
REQ-036 SHALL cover: opa=0x7F000000, opb=0x3F800001 (d=127) -> fracta_out=0x4000000, fractb_out=0x0000001, exp_dn_out=0xFE.
REQ-037 SHALL cover: out_ready=0, three pairs offered -> two accepted, in_ready falls, outputs held constant; out_ready=1 -> all three emerge in order with no loss.
REQ-037A SHALL cover: rst_n pulsed low with two pairs in flight -> out_valid=0 immediately, no stale result after release.
